// File: rtl/serial_adder_seq_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_adder_seq_pkg;

    // Default operand/result width; legal range is 1..32.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Sequencer states: wait for operands, stream bits, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : serial_adder_seq_pkg

// File: rtl/serial_adder_seq_fa_cell.sv
// One-bit full adder used by the serial adder sequencer; purely combinational.
module serial_adder_seq_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    // Sum is the parity of the three inputs, carry is their majority.
    always_comb begin
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
    end

endmodule : serial_adder_seq_fa_cell

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: accepts two operands and a carry-in, adds them
// LSB-first one bit per clock through a single full-adder cell, and presents
// sum, carry-out and signed overflow over a valid/ready handshake.
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_a, bit_b, bit_c;
    logic             fa_s, fa_co;

    // Bits offered to the adder cell: operand LSBs and the ripple carry in RUN, zero otherwise.
    always_comb begin
        bit_a = 1'b0;
        bit_b = 1'b0;
        bit_c = 1'b0;
        if (state_q == RUN) begin
            bit_a = a_sh_q[0];
            bit_b = b_sh_q[0];
            bit_c = carry_q;
        end
    end

    serial_adder_seq_fa_cell u_fa_cell (
        .a  (bit_a),
        .b  (bit_b),
        .c  (bit_c),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state and datapath update: accept in IDLE, shift/add in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Shift right then drop the new bit into the MSB; written this way
                // so it also holds for a one-bit wide result register.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                carry_d          = fa_co;
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                cnt_d            = cnt_q + CNT_ONE;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is still the carry into the MSB on this edge.
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake/status outputs decoded from the state; result outputs straight from flops.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == RUN);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
        fa_a      = bit_a;
        fa_b      = bit_b;
        fa_c      = bit_c;
    end

endmodule : serial_adder_seq

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial adder sequencer. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Streams the operands LSB-first, one bit per clock, through a 1-bit full-adder cell.
- Registers the ripple carry between cycles and shifts each sum bit into a result register.
- Presents the WIDTH-bit sum, carry-out and signed overflow to the downstream consumer over a valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block is idle and can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum, cout, ovf are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.
- fa_a, fa_b, fa_c  output  1 each  current bits presented to the full-adder cell; debug/observation only.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and has priority over every other condition.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, counter=0, carry flop=0, fa_*=0.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b into shift registers, load cin into the carry flop, clear the counter, clear sum, go to RUN.
  - Operands are sampled only on that accept edge; later input changes are ignored.
- State RUN:
  - in_ready=0, busy=1.
  - fa_a/fa_b = LSBs of the operand shift registers; fa_c = carry flop.
  - Each edge:
    - sum bit = fa_a^fa_b^fa_c, shifted into the MSB of the sum register (shift right).
    - Carry flop <= majority(fa_a,fa_b,fa_c).
    - Operand registers shift right by one.
    - Counter increments.
  - On the edge where the counter reaches WIDTH-1:
    - Capture the old carry flop value as carry-into-MSB.
    - Set cout to the new carry and ovf = carry_in_msb ^ cout.
    - Go to DONE.
- State DONE:
  - out_valid=1, busy=0, in_ready=0.
  - sum, cout and ovf hold stable until the edge with out_ready=1; that edge returns the block to IDLE with out_valid=0.
  - Outputs keep their last values in IDLE; they are valid only while out_valid=1.
- Latency: accept on edge E0 → out_valid high after edge E_WIDTH, i.e. exactly WIDTH cycles. Minimum throughput is one result per WIDTH+2 cycles; there is no IDLE/DONE bypass.
- Boundary conditions:
  - WIDTH=1: RUN lasts one edge; ovf = cin ^ cout.
  - out_ready held low: DONE holds indefinitely with outputs stable.
  - out_ready=1 arriving before DONE: ignored.
  - in_valid in RUN/DONE: ignored; the upstream must hold its data until in_ready.
  - rst in any state, including mid-RUN: abort immediately to reset values; no partial result is ever emitted.
- Arithmetic: unsigned modulo 2^WIDTH. No internal width growth beyond the carry flop.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10.
  - Localparam for the default WIDTH.
- One natural sub-module: fa_cell, a purely combinational 1-bit full adder (inputs a, b, c; outputs s, co). It is instantiated once.
- The sequencer owns all flops, the counter and the FSM.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0 → after 8 cycles out_valid=1, sum=0x96, cout=0, ovf=1; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then hold out_ready=0 for 5 cycles → out_valid and outputs stable; out_ready=1 → IDLE, in_ready=1 on the next cycle.
- Change a/b/in_valid during RUN → result unchanged, no second accept; back-to-back transactions with out_ready tied high complete every WIDTH+2 cycles.
- Assert rst for 1 cycle at RUN bit 3 → all outputs at reset values next cycle, out_valid never pulses. A following transaction 0x10+0x20 → sum=0x30.
- WIDTH=1 build: a=1, b=1, cin=1 → after 1 cycle sum=1, cout=1, ovf=0. Random regression of 1000 vectors at WIDTH=8 and WIDTH=32 against a reference model.
